bram_stream_reader: RTL and testbench

//  Parametrised successor of the BRAM reader between the PS-written BRAM and the conv filter.

---
 rtl/bram_reader_pkg.sv | 19 +
 rtl/word_unpacker.sv | 85 ++++++++
 rtl/bram_stream_reader.sv | 190 +++++++++++++++++++
 tb/tb_bram_stream_reader.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_reader_pkg.sv
// Shared FSM state type and word/pixel geometry helpers for the BRAM stream reader.
package bram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        KLOAD,
        ISTREAM,
        FINISH
    } state_t;

    function automatic int pix_per_word(input int data_width, input int pixel_size);
        return data_width / pixel_size;
    endfunction

    function automatic int word_bytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/word_unpacker.sv
// Two-entry word FIFO that unpacks each word LSB-first into pixels on a valid/ready port.
module word_unpacker
    import bram_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PIXEL_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic [1:0]            inflight,
    output logic                  space_avail,
    output logic [PIXEL_SIZE-1:0] pixel,
    output logic                  pixel_valid,
    input  logic                  pixel_ready,
    output logic                  pixel_last
);

    localparam int PPW = pix_per_word(DATA_WIDTH, PIXEL_SIZE);
    localparam int SEL_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(PPW - 1);

    logic [DATA_WIDTH-1:0] word_reg [2];
    logic                  last_reg [2];
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [1:0]            count_reg;
    logic [SEL_W-1:0]      sel_reg;

    logic [DATA_WIDTH-1:0] head_word;
    logic                  head_last;
    logic                  xfer;
    logic                  pop;

    assign head_word   = word_reg[rd_ptr_reg];
    assign head_last   = last_reg[rd_ptr_reg];
    assign pixel_valid = (count_reg != 2'd0);
    assign pixel       = head_word[sel_reg*PIXEL_SIZE +: PIXEL_SIZE];
    assign pixel_last  = pixel_valid && head_last && (sel_reg == SEL_LAST);
    assign xfer        = pixel_valid && pixel_ready;
    assign pop         = xfer && (sel_reg == SEL_LAST);

    // Reads already issued to the BRAM reserve a slot so a return can never overrun the FIFO.
    assign space_avail = ({1'b0, count_reg} + {1'b0, inflight}) < 3'd2;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                word_reg[i] <= '0;
                last_reg[i] <= 1'b0;
            end
        end else if (push) begin
            word_reg[wr_ptr_reg] <= push_data;
            last_reg[wr_ptr_reg] <= push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
            sel_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
                sel_reg    <= '0;
            end else if (xfer) begin
                sel_reg <= sel_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Loads a kernel bank from BRAM and streams a batch of images as pixels with backpressure.
module bram_stream_reader
    import bram_reader_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    PIXEL_SIZE   = 8,
    parameter logic [ADDR_WIDTH-1:0] KERNEL_ADDR  = 32'hA000_0000,
    parameter logic [ADDR_WIDTH-1:0] IMAGE_ADDR   = 32'hA000_0024,
    parameter int                    KERNEL_WORDS = 9,
    parameter int                    IMAGE_WORDS  = 196,
    parameter int                    NUM_IMAGES   = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic [ADDR_WIDTH-1:0]              bram_addr,
    output logic                               bram_en,
    input  logic [DATA_WIDTH-1:0]              bram_data,
    input  logic                               read_kernel,
    output logic [KERNEL_WORDS*DATA_WIDTH-1:0] kernel,
    output logic                               kernel_valid,
    input  logic                               read_image,
    output logic [PIXEL_SIZE-1:0]              pixel,
    output logic                               pixel_valid,
    input  logic                               pixel_ready,
    output logic                               pixel_last,
    output logic [$clog2(NUM_IMAGES+1)-1:0]    image_idx,
    output logic                               busy,
    output logic                               done,
    input  logic                               interrupt
);

    localparam int TOTAL = IMAGE_WORDS * NUM_IMAGES;
    localparam int MAX_WORDS = (TOTAL > KERNEL_WORDS) ? TOTAL : KERNEL_WORDS;
    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int IW_W = $clog2(IMAGE_WORDS + 1);
    localparam int IDX_W = $clog2(NUM_IMAGES + 1);

    localparam logic [CNT_W-1:0]      KW_C     = CNT_W'(KERNEL_WORDS);
    localparam logic [CNT_W-1:0]      KW_LAST  = CNT_W'(KERNEL_WORDS - 1);
    localparam logic [CNT_W-1:0]      TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [IW_W-1:0]       IW_LAST  = IW_W'(IMAGE_WORDS - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_IMAGES - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(word_bytes(DATA_WIDTH));

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] bram_addr_reg;
    logic                  bram_en_reg;
    logic                  data_valid_reg;
    logic [CNT_W-1:0]      rd_cnt_reg;
    logic [CNT_W-1:0]      cap_cnt_reg;
    logic [IW_W-1:0]       rx_word_reg;
    logic [IDX_W-1:0]      image_idx_reg;
    logic                  kernel_valid_reg;
    logic                  done_reg;

    logic       kcap;
    logic       push;
    logic       space_avail;
    logic [1:0] inflight;
    logic       xfer;

    assign bram_addr    = bram_addr_reg;
    assign bram_en      = bram_en_reg;
    assign kernel_valid = kernel_valid_reg;
    assign image_idx    = image_idx_reg;
    assign done         = done_reg;
    assign busy         = (state_reg != IDLE);

    // data_valid_reg marks the cycle a read's data is on bram_data; an abort drops it.
    assign kcap     = data_valid_reg && (state_reg == KLOAD) && !interrupt;
    assign push     = data_valid_reg && (state_reg == ISTREAM) && !interrupt;
    assign inflight = {1'b0, bram_en_reg} + {1'b0, data_valid_reg};
    assign xfer     = pixel_valid && pixel_ready;

    generate
        for (genvar gi = 0; gi < KERNEL_WORDS; gi++) begin : g_bank
            logic [DATA_WIDTH-1:0] word_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (kcap && (cap_cnt_reg == CNT_W'(gi))) begin
                    word_reg <= bram_data;
                end
            end
            assign kernel[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
        end
    endgenerate

    word_unpacker #(
        .DATA_WIDTH(DATA_WIDTH),
        .PIXEL_SIZE(PIXEL_SIZE)
    ) u_unpacker (
        .clk        (clk),
        .reset      (reset),
        .flush      (interrupt),
        .push       (push),
        .push_data  (bram_data),
        .push_last  (rx_word_reg == IW_LAST),
        .inflight   (inflight),
        .space_avail(space_avail),
        .pixel      (pixel),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .pixel_last (pixel_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            bram_addr_reg    <= '0;
            bram_en_reg      <= 1'b0;
            data_valid_reg   <= 1'b0;
            rd_cnt_reg       <= '0;
            cap_cnt_reg      <= '0;
            rx_word_reg      <= '0;
            image_idx_reg    <= '0;
            kernel_valid_reg <= 1'b0;
            done_reg         <= 1'b0;
        end else if (interrupt) begin
            state_reg      <= IDLE;
            bram_en_reg    <= 1'b0;
            data_valid_reg <= 1'b0;
            image_idx_reg  <= '0;
            done_reg       <= 1'b0;
        end else begin
            data_valid_reg <= bram_en_reg;
            bram_en_reg    <= 1'b0;
            done_reg       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (read_kernel) begin
                        state_reg        <= KLOAD;
                        kernel_valid_reg <= 1'b0;
                        bram_en_reg      <= 1'b1;
                        bram_addr_reg    <= KERNEL_ADDR;
                        rd_cnt_reg       <= CNT_W'(1);
                        cap_cnt_reg      <= '0;
                    end else if (read_image) begin
                        state_reg     <= ISTREAM;
                        bram_en_reg   <= 1'b1;
                        bram_addr_reg <= IMAGE_ADDR;
                        rd_cnt_reg    <= CNT_W'(1);
                        rx_word_reg   <= '0;
                        image_idx_reg <= '0;
                    end
                end
                KLOAD: begin
                    if (rd_cnt_reg < KW_C) begin
                        bram_en_reg   <= 1'b1;
                        bram_addr_reg <= bram_addr_reg + STEP;
                        rd_cnt_reg    <= rd_cnt_reg + 1'b1;
                    end
                    if (data_valid_reg) begin
                        cap_cnt_reg <= cap_cnt_reg + 1'b1;
                        if (cap_cnt_reg == KW_LAST) begin
                            kernel_valid_reg <= 1'b1;
                            done_reg         <= 1'b1;
                            state_reg        <= FINISH;
                        end
                    end
                end
                ISTREAM: begin
                    if ((rd_cnt_reg < TOTAL_C) && space_avail) begin
                        bram_en_reg   <= 1'b1;
                        bram_addr_reg <= bram_addr_reg + STEP;
                        rd_cnt_reg    <= rd_cnt_reg + 1'b1;
                    end
                    if (data_valid_reg) begin
                        rx_word_reg <= (rx_word_reg == IW_LAST) ? '0 : rx_word_reg + 1'b1;
                    end
                    if (xfer && pixel_last) begin
                        image_idx_reg <= image_idx_reg + 1'b1;
                        if (image_idx_reg == IDX_LAST) begin
                            done_reg  <= 1'b1;
                            state_reg <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench: stimulus queues expected pixels, a negedge monitor pops and compares transfers.
module tb_bram_stream_reader;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int PS   = 8;
    localparam int KW   = 9;
    localparam int IW   = 16;
    localparam int NI   = 3;
    localparam int IDXW = $clog2(NI + 1);
    localparam int PPI  = IW * (DW / PS);
    localparam int NPIX = PPI * NI;
    localparam logic [31:0] KA = 32'hA000_0000;
    localparam logic [31:0] IA = 32'hA000_0024;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [AW-1:0]   bram_addr;
    logic            bram_en;
    logic [DW-1:0]   bram_data = '0;
    logic            read_kernel = 1'b0;
    logic [KW*DW-1:0] kernel;
    logic            kernel_valid;
    logic            read_image = 1'b0;
    logic [PS-1:0]   pixel;
    logic            pixel_valid;
    logic            pixel_ready = 1'b1;
    logic            pixel_last;
    logic [IDXW-1:0] image_idx;
    logic            busy;
    logic            done;
    logic            interrupt = 1'b0;

    typedef struct packed {
        logic [PS-1:0]   pix;
        logic            last;
        logic [IDXW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   xfer_cnt = 0;
    logic hold_valid = 1'b0;
    exp_t held;

    bram_stream_reader #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .PIXEL_SIZE  (PS),
        .KERNEL_ADDR (KA),
        .IMAGE_ADDR  (IA),
        .KERNEL_WORDS(KW),
        .IMAGE_WORDS (IW),
        .NUM_IMAGES  (NI)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bram_addr   (bram_addr),
        .bram_en     (bram_en),
        .bram_data   (bram_data),
        .read_kernel (read_kernel),
        .kernel      (kernel),
        .kernel_valid(kernel_valid),
        .read_image  (read_image),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel_last  (pixel_last),
        .image_idx   (image_idx),
        .busy        (busy),
        .done        (done),
        .interrupt   (interrupt)
    );

    always #5 clk = ~clk;

    // Address-derived BRAM contents: four distinct bytes per word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0] ^ 8'hC3, a[7:0] ^ 8'h96, a[7:0] ^ 8'h69, a[7:0]};
    endfunction

    always @(posedge clk) begin
        if (bram_en) bram_data <= mem_word(bram_addr);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_batch(input int n);
        for (int p = 0; p < n; p++) begin
            exp_t        e;
            logic [31:0] a;
            logic [31:0] d;
            a = IA + 32'(4 * (p / 4));
            d = mem_word(a);
            e.pix  = d[8*(p%4) +: 8];
            e.last = ((p % PPI) == PPI - 1);
            e.idx  = IDXW'(p / PPI);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int base, input string name);
        int n = 0;
        while (done_cnt == base && n < 5000) begin
            step();
            n++;
        end
        chk(name, 64'(done_cnt > base), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, 64'(bram_addr), 64'd0);
        chk({tag, "_en"}, 64'(bram_en), 64'd0);
        chk({tag, "_kernel_nz"}, 64'(|kernel), 64'd0);
        chk({tag, "_kvalid"}, 64'(kernel_valid), 64'd0);
        chk({tag, "_pixel"}, 64'(pixel), 64'd0);
        chk({tag, "_pvalid"}, 64'(pixel_valid), 64'd0);
        chk({tag, "_plast"}, 64'(pixel_last), 64'd0);
        chk({tag, "_idx"}, 64'(image_idx), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    task automatic chk_bank(input string tag);
        for (int i = 0; i < KW; i++) begin
            chk($sformatf("%s_word%0d", tag, i), 64'(kernel[i*DW +: DW]), 64'(mem_word(KA + 32'(4 * i))));
        end
    endtask

    task automatic monitor();
        exp_t cur;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            cur = {pixel, pixel_last, image_idx};
            if (hold_valid && pixel_valid && !reset) begin
                total++;
                if (cur !== held) begin
                    bad++;
                    $display("FAIL stall_hold: got %0h want %0h", cur, held);
                end
            end
            if (!reset && !interrupt && pixel_valid && pixel_ready) begin
                xfer_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pixel: got %0h want none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        bad++;
                        $display("FAIL pixel_xfer%0d: got pix=%0h last=%0b idx=%0d want pix=%0h last=%0b idx=%0d",
                                 xfer_cnt, cur.pix, cur.last, cur.idx, e.pix, e.last, e.idx);
                    end
                end
            end
            hold_valid = pixel_valid && !pixel_ready && !reset && !interrupt;
            held = cur;
        end
    endtask

    task automatic stimulus();
        int base;
        int bx;
        int nval;
        int bub;
        int n;
        int iss;
        int cons;
        int xf;
        int maxo;

        // reset state
        repeat (3) step();
        chk_all_zero("reset");
        reset = 1'b0;
        step();

        // 1: kernel load
        $display("txn read_kernel");
        base = done_cnt;
        read_kernel = 1'b1;
        step();
        read_kernel = 1'b0;
        for (int k = 1; k <= KW; k++) begin
            chk($sformatf("kload_en%0d", k), 64'(bram_en), 64'd1);
            chk($sformatf("kload_addr%0d", k), 64'(bram_addr), 64'(KA + 32'(4 * (k - 1))));
            step();
        end
        chk("kload_en_off", 64'(bram_en), 64'd0);
        chk("kload_kvalid_early", 64'(kernel_valid), 64'd0);
        step();
        chk("kload_kvalid_c11", 64'(kernel_valid), 64'd1);
        chk("kload_done_c11", 64'(done), 64'd1);
        chk("kload_busy_finish", 64'(busy), 64'd1);
        step();
        chk("kload_done_pulse", 64'(done), 64'd0);
        chk("kload_idle", 64'(busy), 64'd0);
        chk_bank("kbank");
        chk("kload_done_count", 64'(done_cnt - base), 64'd1);

        // 2: full batch, ready held high
        $display("txn read_image ready=1");
        push_batch(NPIX);
        base = done_cnt;
        read_image = 1'b1;
        step();
        read_image = 1'b0;
        chk("img_first_en", 64'(bram_en), 64'd1);
        chk("img_first_addr", 64'(bram_addr), 64'(IA));
        chk("img_valid_c1", 64'(pixel_valid), 64'd0);
        step();
        chk("img_valid_c2", 64'(pixel_valid), 64'd0);
        step();
        chk("img_valid_c3", 64'(pixel_valid), 64'd1);
        nval = 0;
        bub = 0;
        n = 0;
        while (!done && n < 2000) begin
            if (pixel_valid) nval++;
            else bub++;
            step();
            n++;
        end
        chk("img_valid_cycles", 64'(nval), 64'(NPIX));
        chk("img_bubbles", 64'(bub), 64'd0);
        chk("img_done_seen", 64'(done), 64'd1);
        step();
        chk("img_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("img_done_count", 64'(done_cnt - base), 64'd1);
        chk("img_idle", 64'(busy), 64'd0);

        // 3: same batch, ready high one cycle in three
        $display("txn read_image ready=1/3");
        push_batch(NPIX);
        base = done_cnt;
        iss = 0;
        cons = 0;
        xf = 0;
        maxo = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #2;
            pixel_ready = ((c % 3) == 0);
            read_image = (c == 0);
            #1;
            if (bram_en) iss++;
            if (iss - cons > maxo) maxo = iss - cons;
            if (pixel_valid && pixel_ready) begin
                xf++;
                if ((xf % 4) == 0) cons++;
            end
            if (done) break;
        end
        pixel_ready = 1'b1;
        read_image = 1'b0;
        chk("stall_outstanding_le2", 64'(maxo <= 2), 64'd1);
        chk("stall_xfers", 64'(xf), 64'(NPIX));
        step();
        chk("stall_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("stall_done_count", 64'(done_cnt - base), 64'd1);

        // 4: abort while pixel 40 is presented, then restart from pixel 0
        $display("txn read_image abort@40");
        push_batch(40);
        base = done_cnt;
        bx = xfer_cnt;
        read_image = 1'b1;
        step();
        read_image = 1'b0;
        n = 0;
        while (xfer_cnt - bx < 40 && n < 1000) begin
            step();
            n++;
        end
        chk("abort_reach40", 64'(xfer_cnt - bx), 64'd40);
        chk("abort_p40_valid", 64'(pixel_valid), 64'd1);
        pixel_ready = 1'b0;
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        pixel_ready = 1'b1;
        chk("abort_pvalid", 64'(pixel_valid), 64'd0);
        chk("abort_bram_en", 64'(bram_en), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (10) step();
        chk("abort_no_done", 64'(done_cnt - base), 64'd0);
        chk("abort_xfers", 64'(xfer_cnt - bx), 64'd40);
        chk("abort_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("txn read_image restart");
        push_batch(NPIX);
        base = done_cnt;
        read_image = 1'b1;
        step();
        read_image = 1'b0;
        wait_done(base, "restart_done_timeout");
        step();
        chk("restart_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("restart_done_count", 64'(done_cnt - base), 64'd1);

        // 5a: abort during kernel word 4
        $display("txn read_kernel abort@4");
        base = done_cnt;
        read_kernel = 1'b1;
        step();
        read_kernel = 1'b0;
        chk("kabort_kvalid_cleared", 64'(kernel_valid), 64'd0);
        n = 0;
        while (!(bram_en && bram_addr == KA + 32'd16) && n < 20) begin
            step();
            n++;
        end
        chk("kabort_word4_seen", 64'(bram_addr), 64'(KA + 32'd16));
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        chk("kabort_busy", 64'(busy), 64'd0);
        chk("kabort_bram_en", 64'(bram_en), 64'd0);
        repeat (12) step();
        chk("kabort_kvalid", 64'(kernel_valid), 64'd0);
        chk("kabort_no_done", 64'(done_cnt - base), 64'd0);
        chk_bank("kabort_bank");

        // 5b: reset in the middle of a stream
        $display("txn read_image reset@20");
        push_batch(NPIX);
        bx = xfer_cnt;
        read_image = 1'b1;
        step();
        read_image = 1'b0;
        n = 0;
        while (xfer_cnt - bx < 20 && n < 1000) begin
            step();
            n++;
        end
        chk("rst_mid_reach20", 64'(xfer_cnt - bx >= 20), 64'd1);
        reset = 1'b1;
        step();
        chk_all_zero("rst_mid");
        reset = 1'b0;
        exp_q.delete();
        step();

        // 6: both commands high, kernel first then images
        $display("txn read_kernel+read_image");
        push_batch(NPIX);
        base = done_cnt;
        read_kernel = 1'b1;
        read_image = 1'b1;
        step();
        read_kernel = 1'b0;
        chk("both_kload_addr", 64'(bram_addr), 64'(KA));
        chk("both_kload_en", 64'(bram_en), 64'd1);
        wait_done(base, "both_kdone_timeout");
        n = 0;
        while (!(bram_en && bram_addr == IA) && n < 10) begin
            step();
            n++;
        end
        chk("both_img_start", 64'(bram_addr), 64'(IA));
        read_image = 1'b0;
        chk("both_kvalid", 64'(kernel_valid), 64'd1);
        chk("both_busy", 64'(busy), 64'd1);
        wait_done(base + 1, "both_idone_timeout");
        step();
        chk("both_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("both_done_count", 64'(done_cnt - base), 64'd2);
        chk_bank("both_bank");
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            begin
                #2_000_000;
                total++;
                bad++;
                $display("FAIL watchdog: got timeout want completion");
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
